// File: rtl/fft_pkg.sv
// Shared controller state type and bit-reverse helper for the FFT ping-pong sample RAM.
package fft_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fft_state_e;

  // Reverses the low w bits of v; w is a constant at every call site.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] src;
    logic [31:0] r;
    src = v;
    r   = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r   = {r[30:0], src[0]};
      src = src >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank_mem.sv
// One complex sample bank: two synchronous write ports and two registered read ports, read-first.
module fft_bank_mem #(
  parameter int BIT_WIDTH = 29,
  parameter int N         = 16,
  parameter int LOG2N     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_a_i,
  input  logic [LOG2N-1:0]            wadr_a_i,
  input  logic signed [BIT_WIDTH-1:0] wre_a_i,
  input  logic signed [BIT_WIDTH-1:0] wim_a_i,
  input  logic                        we_b_i,
  input  logic [LOG2N-1:0]            wadr_b_i,
  input  logic signed [BIT_WIDTH-1:0] wre_b_i,
  input  logic signed [BIT_WIDTH-1:0] wim_b_i,
  input  logic                        re_i,
  input  logic [LOG2N-1:0]            radr_a_i,
  input  logic [LOG2N-1:0]            radr_b_i,
  output logic signed [BIT_WIDTH-1:0] rre_a_o,
  output logic signed [BIT_WIDTH-1:0] rim_a_o,
  output logic signed [BIT_WIDTH-1:0] rre_b_o,
  output logic signed [BIT_WIDTH-1:0] rim_b_o
);

  logic [2*BIT_WIDTH-1:0] mem_q [N];
  logic [2*BIT_WIDTH-1:0] rdata_a_q;
  logic [2*BIT_WIDTH-1:0] rdata_b_q;

  // Port B is written last so it wins when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[wadr_a_i] <= {wre_a_i, wim_a_i};
    if (we_b_i) mem_q[wadr_b_i] <= {wre_b_i, wim_b_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else if (re_i) begin
      rdata_a_q <= mem_q[radr_a_i];
      rdata_b_q <= mem_q[radr_b_i];
    end
  end

  assign rre_a_o = rdata_a_q[2*BIT_WIDTH-1:BIT_WIDTH];
  assign rim_a_o = rdata_a_q[BIT_WIDTH-1:0];
  assign rre_b_o = rdata_b_q[2*BIT_WIDTH-1:BIT_WIDTH];
  assign rim_b_o = rdata_b_q[BIT_WIDTH-1:0];

endmodule

// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample RAM between a streaming loader and an FFT butterfly engine.
// Define FFT_RAM_BITREV_EN to load frames at bit-reversed addresses; otherwise natural order.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = 29,
  parameter int N         = 16,
  parameter int LOG2N     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] in_re,
  input  logic signed [BIT_WIDTH-1:0] in_im,
  output logic                        start_o,
  output logic                        bank_o,
  output logic                        busy_o,
  input  logic                        rd_en,
  input  logic [LOG2N-1:0]            rd_adr_a,
  input  logic [LOG2N-1:0]            rd_adr_b,
  output logic signed [BIT_WIDTH-1:0] rd_re_a,
  output logic signed [BIT_WIDTH-1:0] rd_im_a,
  output logic signed [BIT_WIDTH-1:0] rd_re_b,
  output logic signed [BIT_WIDTH-1:0] rd_im_b,
  output logic                        rd_valid,
  input  logic                        wr_en,
  input  logic [LOG2N-1:0]            wr_adr_a,
  input  logic [LOG2N-1:0]            wr_adr_b,
  input  logic signed [BIT_WIDTH-1:0] wr_re_a,
  input  logic signed [BIT_WIDTH-1:0] wr_im_a,
  input  logic signed [BIT_WIDTH-1:0] wr_re_b,
  input  logic signed [BIT_WIDTH-1:0] wr_im_b,
  input  logic                        fft_done,
  output logic                        ovf_o
);

  // Handshake: a sample moves on any rising clk edge where in_valid and in_ready are both high.
  fft_state_e       state_q, state_d;
  logic             bank_q, bank_d;
  logic             full_q, full_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             start_q, start_d;
  logic             ovf_q, ovf_d;
  logic             rd_valid_q;
  logic             rd_sel_q;
  logic [LOG2N-1:0] load_adr;
  logic             load_fire, cmp_rd, cmp_wr;

  assign in_ready  = ~full_q;
  assign load_fire = in_valid & ~full_q;
  assign cmp_rd    = rd_en & (state_q == ST_RUN);
  assign cmp_wr    = wr_en & (state_q == ST_RUN);

`ifdef FFT_RAM_BITREV_EN
  assign load_adr = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));
`else
  assign load_adr = wr_cnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    full_d   = full_q;
    wr_cnt_d = wr_cnt_q;
    start_d  = 1'b0;
    ovf_d    = ovf_q | (in_valid & ~in_ready);
    if (load_fire) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_cnt_q == LOG2N'(N - 1)) full_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (full_q) begin
          bank_d  = ~bank_q;
          start_d = 1'b1;
          full_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fft_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bank_q     <= 1'b0;
      full_q     <= 1'b0;
      wr_cnt_q   <= '0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      full_q     <= full_d;
      wr_cnt_q   <= wr_cnt_d;
      start_q    <= start_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= cmp_rd;
      if (cmp_rd) rd_sel_q <= bank_q;
    end
  end

  logic signed [BIT_WIDTH-1:0] bre_a [2];
  logic signed [BIT_WIDTH-1:0] bim_a [2];
  logic signed [BIT_WIDTH-1:0] bre_b [2];
  logic signed [BIT_WIDTH-1:0] bim_b [2];

  // The bank not owned by compute is the load bank, so the two writers never share a bank.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_load;
    assign is_load = (bank_q != 1'(b));

    fft_bank_mem #(.BIT_WIDTH(BIT_WIDTH), .N(N), .LOG2N(LOG2N)) u_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_a_i   (is_load ? load_fire : cmp_wr),
      .wadr_a_i (is_load ? load_adr : wr_adr_a),
      .wre_a_i  (is_load ? in_re : wr_re_a),
      .wim_a_i  (is_load ? in_im : wr_im_a),
      .we_b_i   (~is_load & cmp_wr),
      .wadr_b_i (wr_adr_b),
      .wre_b_i  (wr_re_b),
      .wim_b_i  (wr_im_b),
      .re_i     (~is_load & cmp_rd),
      .radr_a_i (rd_adr_a),
      .radr_b_i (rd_adr_b),
      .rre_a_o  (bre_a[b]),
      .rim_a_o  (bim_a[b]),
      .rre_b_o  (bre_b[b]),
      .rim_b_o  (bim_b[b])
    );
  end

  assign rd_re_a  = bre_a[rd_sel_q];
  assign rd_im_a  = bim_a[rd_sel_q];
  assign rd_re_b  = bre_b[rd_sel_q];
  assign rd_im_b  = bim_b[rd_sel_q];
  assign rd_valid = rd_valid_q;
  assign start_o  = start_q;
  assign bank_o   = bank_q;
  assign busy_o   = (state_q == ST_RUN);
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram with a per-cycle reference model of the ping-pong RAM.
module tb_fft_pingpong_ram;

  localparam int BW = 29;
  localparam int N  = 16;
  localparam int L  = 4;

`ifdef FFT_RAM_BITREV_EN
  localparam int E_ADR8 = 1;
  localparam int E_ADR1 = 8;
`else
  localparam int E_ADR8 = 8;
  localparam int E_ADR1 = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [BW-1:0] in_re = '0, in_im = '0;
  logic                 start_o, bank_o, busy_o;
  logic                 rd_en = 1'b0;
  logic [L-1:0]         rd_adr_a = '0, rd_adr_b = '0;
  logic signed [BW-1:0] rd_re_a, rd_im_a, rd_re_b, rd_im_b;
  logic                 rd_valid;
  logic                 wr_en = 1'b0;
  logic [L-1:0]         wr_adr_a = '0, wr_adr_b = '0;
  logic signed [BW-1:0] wr_re_a = '0, wr_im_a = '0, wr_re_b = '0, wr_im_b = '0;
  logic                 fft_done = 1'b0;
  logic                 ovf_o;

  fft_pingpong_ram #(.BIT_WIDTH(BW), .N(N), .LOG2N(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .start_o(start_o), .bank_o(bank_o), .busy_o(busy_o),
    .rd_en(rd_en), .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b),
    .rd_re_a(rd_re_a), .rd_im_a(rd_im_a), .rd_re_b(rd_re_b), .rd_im_b(rd_im_b),
    .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b),
    .wr_re_a(wr_re_a), .wr_im_a(wr_im_a), .wr_re_b(wr_re_b), .wr_im_b(wr_im_b),
    .fft_done(fft_done), .ovf_o(ovf_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_adr(input int k);
`ifdef FFT_RAM_BITREV_EN
    int r;
    r = 0;
    for (int i = 0; i < L; i++)
      if ((k & (1 << i)) != 0) r += 1 << (L - 1 - i);
    return r;
`else
    return k;
`endif
  endfunction

  // ---------------- reference model ----------------
  logic signed [BW-1:0] m_re [2][N];
  logic signed [BW-1:0] m_im [2][N];
  bit                   m_kn [2][N];
  bit m_bank = 0, m_full = 0, m_busy = 0, m_start = 0, m_rdv = 0, m_ovf = 0, m_rd_kn = 1;
  bit nx_bank, nx_full, nx_busy, nx_start;
  int m_cnt = 0;
  int la;
  logic signed [BW-1:0] m_ra = '0, m_ia = '0, m_rb = '0, m_ib = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bank = 0; m_full = 0; m_busy = 0; m_start = 0; m_rdv = 0; m_ovf = 0;
      m_cnt = 0; m_ra = '0; m_ia = '0; m_rb = '0; m_ib = '0; m_rd_kn = 1;
    end else begin
      nx_bank = m_bank; nx_full = m_full; nx_busy = m_busy; nx_start = 0;
      if (in_valid && m_full) m_ovf = 1;
      m_rdv = m_busy && rd_en;
      if (m_rdv) begin
        m_ra = m_re[m_bank][rd_adr_a]; m_ia = m_im[m_bank][rd_adr_a];
        m_rb = m_re[m_bank][rd_adr_b]; m_ib = m_im[m_bank][rd_adr_b];
        m_rd_kn = m_kn[m_bank][rd_adr_a] && m_kn[m_bank][rd_adr_b];
      end
      if (m_busy && wr_en) begin
        m_re[m_bank][wr_adr_a] = wr_re_a; m_im[m_bank][wr_adr_a] = wr_im_a; m_kn[m_bank][wr_adr_a] = 1;
        m_re[m_bank][wr_adr_b] = wr_re_b; m_im[m_bank][wr_adr_b] = wr_im_b; m_kn[m_bank][wr_adr_b] = 1;
      end
      if (in_valid && !m_full) begin
        la = ref_adr(m_cnt);
        m_re[!m_bank][la] = in_re; m_im[!m_bank][la] = in_im; m_kn[!m_bank][la] = 1;
        if (m_cnt == N - 1) begin
          nx_full = 1;
          m_cnt = 0;
        end else m_cnt++;
      end
      if (!m_busy && m_full) begin
        nx_bank = !m_bank; nx_start = 1; nx_full = 0; nx_busy = 1;
      end else if (m_busy && fft_done) nx_busy = 0;
      m_bank = nx_bank; m_full = nx_full; m_busy = nx_busy; m_start = nx_start;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_full);
    chk("start_o", start_o, m_start);
    chk("bank_o", bank_o, m_bank);
    chk("busy_o", busy_o, m_busy);
    chk("rd_valid", rd_valid, m_rdv);
    chk("ovf_o", ovf_o, m_ovf);
    if (m_rd_kn) begin
      chk("rd_re_a", rd_re_a, m_ra);
      chk("rd_im_a", rd_im_a, m_ia);
      chk("rd_re_b", rd_re_b, m_rb);
      chk("rd_im_b", rd_im_b, m_ib);
    end
    if (start_o) start_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic push(input int re, input int im);
    in_valid = 1'b1; in_re = BW'(re); in_im = BW'(im);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wr(input int aa, input int ab, input int ra, input int rb);
    wr_en = 1'b1; wr_adr_a = L'(aa); wr_adr_b = L'(ab);
    wr_re_a = BW'(ra); wr_im_a = BW'(-ra); wr_re_b = BW'(rb); wr_im_b = BW'(-rb);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int a, input int b, input int ea, input int eb);
    rd_en = 1'b1; rd_adr_a = L'(a); rd_adr_b = L'(b);
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, rd_valid, 1);
    chk({name, "_re_a"}, rd_re_a, ea);
    chk({name, "_re_b"}, rd_re_b, eb);
    sync();
  endtask

  task automatic wait_start(input string name, input int budget);
    bit got;
    got = 0;
    repeat (budget) begin
      @(negedge clk);
      if (start_o) begin
        got = 1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in_ready"}, in_ready, 1);
    chk({name, "_start"}, start_o, 0);
    chk({name, "_bank"}, bank_o, 0);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_rd_valid"}, rd_valid, 0);
    chk({name, "_ovf"}, ovf_o, 0);
    chk({name, "_rd_re_a"}, rd_re_a, 0);
    chk({name, "_rd_im_b"}, rd_im_b, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("por");
    sync();

    // Compute-side access while idle must be ignored.
    rd_en = 1'b1; wr_en = 1'b1; wr_adr_a = 4'd2; wr_re_a = 29'sd99;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("idle_rd_ignored", rd_valid, 0);
    sync();

    // Frame 1: re=k, im=-k.
    start_cnt = 0;
    for (int k = 0; k < N; k++) push(k, -k);
    wait_start("frame1_start", 8);
    chk("frame1_bank", bank_o, 1);
    sync();
    repeat (3) @(posedge clk);
    #1;
    chk("frame1_one_start", start_cnt, 1);
    rd_chk("ld_order", 8, 1, E_ADR8, E_ADR1);
    chk("ld_order_im_a", rd_im_a, -E_ADR8);

    // Read-first collision and same-address write.
    wr(3, 9, 5, 77);
    wr_en = 1'b1; wr_adr_a = 4'd3; wr_re_a = 29'sd100; wr_im_a = -29'sd100;
    wr_adr_b = 4'd10; wr_re_b = 29'sd33; wr_im_b = -29'sd33;
    rd_en = 1'b1; rd_adr_a = 4'd3; rd_adr_b = 4'd9;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("read_first_old", rd_re_a, 5);
    chk("read_first_b", rd_re_b, 77);
    sync();
    rd_chk("after_write", 3, 10, 100, 33);
    wr(6, 6, 111, 222);
    rd_chk("same_adr_b_wins", 6, 6, 222, 222);

    // Back-pressure: second frame with no fft_done.
    for (int k = 0; k < N; k++) push(200 + k, k);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_ovf_clear", ovf_o, 0);
    sync();
    push(300, 0);
    @(negedge clk);
    chk("bp_ovf_set", ovf_o, 1);
    chk("bp_no_swap", bank_o, 1);
    sync();

    // Release, then fft_done coinciding with the 16th accept of the next frame.
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    wait_start("frame2_start", 8);
    chk("frame2_bank", bank_o, 0);
    sync();
    for (int k = 0; k < N - 1; k++) push(400 + k, -k);
    fft_done = 1'b1;
    push(415, -15);
    fft_done = 1'b0;
    @(negedge clk);
    chk("sim_busy_gap", busy_o, 0);
    chk("sim_no_start_yet", start_o, 0);
    @(negedge clk);
    chk("sim_busy_back", busy_o, 1);
    chk("sim_start", start_o, 1);
    chk("sim_bank", bank_o, 1);
    chk("sim_ovf_sticky", ovf_o, 1);
    sync();

    // Reset after 7 accepts of a partial frame.
    for (int k = 0; k < 7; k++) push(600 + k, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    sync();
    rst_n = 1'b1;
    start_cnt = 0;
    for (int k = 0; k < N; k++) push(50 + k, k);
    repeat (6) @(negedge clk);
    chk("post_rst_one_start", start_cnt, 1);
    chk("post_rst_bank", bank_o, 1);
    sync();
    rd_chk("post_rst_rd", 8, 0, 50 + E_ADR8, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
